// File: rtl/maxnet_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_host_driver
// Description : Host-side sequencer for the Maxnet engine. Collects epsilon
//               and four activation words from a valid/ready stream, pulses
//               the engine start, waits for finish and hands the captured
//               winner/overflow back on a valid/ready result port.
//               Optional feature macro: MAXNET_TIMEOUT_EN (WAIT-state budget
//               of TIMEOUT_CYCLES cycles, reported through res_timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_host_driver #(
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    // host word stream: epsilon, a1, a2, a3, a4
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    // engine side
    output logic              mx_start,
    output logic [WORD_W-1:0] mx_epsilon,
    output logic [WORD_W-1:0] mx_a1,
    output logic [WORD_W-1:0] mx_a2,
    output logic [WORD_W-1:0] mx_a3,
    output logic [WORD_W-1:0] mx_a4,
    input  logic              mx_finish,
    input  logic              mx_overflow,
    input  logic [WORD_W-1:0] mx_out,
    // result port
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              res_overflow,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] c_LAST_WORD = 3'd4;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [2:0]        r_word_cnt;
    logic              w_accept;
    logic              w_expire;

    logic [WORD_W-1:0] r_epsilon;
    logic [WORD_W-1:0] r_a1;
    logic [WORD_W-1:0] r_a2;
    logic [WORD_W-1:0] r_a3;
    logic [WORD_W-1:0] r_a4;
    logic [WORD_W-1:0] r_res_data;
    logic              r_res_overflow;

    // All handshake/status outputs decode straight from the state register,
    // so an asynchronous reset drives them to idle values with no clock.
    assign in_ready   = (r_state == S_LOAD);
    assign mx_start   = (r_state == S_START);
    assign res_valid  = (r_state == S_RESP);
    assign busy       = (r_state == S_START) || (r_state == S_WAIT);
    assign w_accept   = (r_state == S_LOAD) && in_valid;

    assign mx_epsilon   = r_epsilon;
    assign mx_a1        = r_a1;
    assign mx_a2        = r_a2;
    assign mx_a3        = r_a3;
    assign mx_a4        = r_a4;
    assign res_data     = r_res_data;
    assign res_overflow = r_res_overflow;

`ifdef MAXNET_TIMEOUT_EN
    localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_res_timeout;

    // The counter is zero on the first WAIT cycle; the last budgeted WAIT
    // cycle is therefore the one where it equals TIMEOUT_CYCLES-1.
    assign w_expire    = (r_state == S_WAIT) && (r_wait_cnt == c_WAIT_LAST);
    assign res_timeout = r_res_timeout;

    // WAIT-cycle counter, cleared while the start pulse is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_START) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Timeout flag: a finish arriving in the expiry cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_timeout <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (mx_finish) begin
                r_res_timeout <= 1'b0;
            end else if (w_expire) begin
                r_res_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout_cfg;

    // Without the timeout feature WAIT holds until the engine finishes.
    assign w_expire             = 1'b0;
    assign res_timeout          = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept && (r_word_cnt == c_LAST_WORD)) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (mx_finish || w_expire) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // Word index within the current job; wraps to zero on the fifth word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= 3'd0;
        end else if (w_accept) begin
            if (r_word_cnt == c_LAST_WORD) begin
                r_word_cnt <= 3'd0;
            end else begin
                r_word_cnt <= r_word_cnt + 3'd1;
            end
        end
    end

    // Operand registers, written only by accepted LOAD words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epsilon <= '0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_a3      <= '0;
            r_a4      <= '0;
        end else if (w_accept) begin
            case (r_word_cnt)
                3'd0:    r_epsilon <= in_data;
                3'd1:    r_a1      <= in_data;
                3'd2:    r_a2      <= in_data;
                3'd3:    r_a3      <= in_data;
                3'd4:    r_a4      <= in_data;
                default: r_a4      <= r_a4;
            endcase
        end
    end

    // Result capture; a timeout (no finish) reports zero data and overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data     <= '0;
            r_res_overflow <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (mx_finish) begin
                r_res_data     <= mx_out;
                r_res_overflow <= mx_overflow;
            end else if (w_expire) begin
                r_res_data     <= '0;
                r_res_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxnet_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_host_driver
// Description : Directed self-checking bench for maxnet_host_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_host_driver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mx_start;
    logic [31:0] mx_epsilon;
    logic [31:0] mx_a1;
    logic [31:0] mx_a2;
    logic [31:0] mx_a3;
    logic [31:0] mx_a4;
    logic        mx_finish;
    logic        mx_overflow;
    logic [31:0] mx_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_overflow;
    logic        res_timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    maxnet_host_driver #(
        .WORD_W        (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mx_start    (mx_start),
        .mx_epsilon  (mx_epsilon),
        .mx_a1       (mx_a1),
        .mx_a2       (mx_a2),
        .mx_a3       (mx_a3),
        .mx_a4       (mx_a4),
        .mx_finish   (mx_finish),
        .mx_overflow (mx_overflow),
        .mx_out      (mx_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_overflow(res_overflow),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream five words back to back; returns in the START cycle.
    task automatic load_job(input logic [31:0] e, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3,
                            input logic [31:0] a4);
        logic [31:0] w [5];
        w[0] = e; w[1] = a1; w[2] = a2; w[3] = a3; w[4] = a4;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, mx_start, busy, res_valid, res_overflow, res_timeout} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b",
                     {in_ready, mx_start, busy, res_valid, res_overflow, res_timeout}, 6'b100000);
        end
        n_checks++;
        if ({mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, res_data} !== 192'h0) begin
            n_fail++;
            $display("FAIL reset_words: got %h expected 0",
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, res_data});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, busy, res_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", {in_ready, busy, res_valid}, 3'b100);
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] w [5];
        w[0] = 32'd5; w[1] = 32'd100; w[2] = 32'd300; w[3] = 32'd200; w[4] = 32'd50;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = w[i];
            n_checks++;
            if (in_ready !== 1'b1 || mx_start !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_load_ready word %0d: got ready=%b start=%b expected ready=1 start=0",
                         i, in_ready, mx_start);
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
        n_checks++;
        if ({mx_start, in_ready, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL basic_start_pulse: got %b expected %b", {mx_start, in_ready, busy}, 3'b101);
        end
        n_checks++;
        if ({mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {w[0], w[1], w[2], w[3], w[4]}) begin
            n_fail++;
            $display("FAIL basic_operands: got %h expected %h",
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4}, {w[0], w[1], w[2], w[3], w[4]});
        end
        tick();
        n_checks++;
        if ({mx_start, in_ready, busy, res_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL basic_wait_entry: got %b expected %b",
                     {mx_start, in_ready, busy, res_valid}, 4'b0010);
        end
    endtask

    // Continues from the first WAIT cycle (start + 1) of test_basic_load.
    task automatic test_result_capture();
        for (int k = 2; k <= 7; k++) begin
            mx_out = 32'hBEEF_0000 + k;
            tick();
            n_checks++;
            if (res_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL capture_wait cycle %0d: got valid=%b busy=%b expected valid=0 busy=1",
                         k, res_valid, busy);
            end
        end
        mx_finish   = 1'b1;
        mx_out      = 32'd300;
        mx_overflow = 1'b0;
        tick();
        mx_finish = 1'b0;
        mx_out    = 32'hDEAD_DEAD;
        n_checks++;
        if ({res_valid, in_ready, busy, res_overflow, res_timeout} !== 5'b10000 || res_data !== 32'd300) begin
            n_fail++;
            $display("FAIL capture_result: got flags=%b data=%0d expected flags=10000 data=300",
                     {res_valid, in_ready, busy, res_overflow, res_timeout}, res_data);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== 32'd300) begin
                n_fail++;
                $display("FAIL capture_backpressure %0d: got valid=%b ready=%b data=%0d expected 1 0 300",
                         k, res_valid, in_ready, res_data);
            end
        end
        n_checks++;
        if ({mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {32'd5, 32'd100, 32'd300, 32'd200, 32'd50}) begin
            n_fail++;
            $display("FAIL capture_operands_stable: got %h", {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if ({in_ready, res_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL capture_handshake: got %b expected %b", {in_ready, res_valid, busy}, 3'b100);
        end
        // finish while loading must be ignored
        mx_finish   = 1'b1;
        mx_out      = 32'h77;
        mx_overflow = 1'b1;
        tick();
        mx_finish   = 1'b0;
        mx_overflow = 1'b0;
        n_checks++;
        if ({in_ready, res_valid, busy, res_overflow} !== 4'b1000 || res_data !== 32'd300) begin
            n_fail++;
            $display("FAIL finish_in_load: got flags=%b data=%0d expected flags=1000 data=300",
                     {in_ready, res_valid, busy, res_overflow}, res_data);
        end
    endtask

    task automatic test_bubbled();
        logic [31:0] w [5];
        w[0] = 32'd7; w[1] = 32'd11; w[2] = 32'd13; w[3] = 32'd17; w[4] = 32'd19;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
            in_valid = 1'b0;
            in_data  = 32'hBAD0_0000;
            if (i < 4) begin
                n_checks++;
                if (mx_start !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bubble_early_start word %0d: got start=%b ready=%b expected 0 1",
                             i, mx_start, in_ready);
                end
                tick();
            end
        end
        n_checks++;
        if (mx_start !== 1'b1 ||
            {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {w[0], w[1], w[2], w[3], w[4]}) begin
            n_fail++;
            $display("FAIL bubble_operands: got start=%b ops=%h expected start=1 ops=%h", mx_start,
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4}, {w[0], w[1], w[2], w[3], w[4]});
        end
        in_valid = 1'b1;
        in_data  = 32'h999;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 ||
            {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {w[0], w[1], w[2], w[3], w[4]}) begin
            n_fail++;
            $display("FAIL bubble_wait_ignored: got ready=%b ops=%h expected ready=0 ops=%h", in_ready,
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4}, {w[0], w[1], w[2], w[3], w[4]});
        end
        in_valid  = 1'b0;
        mx_finish = 1'b1;
        mx_out    = 32'd19;
        tick();
        mx_finish = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd19) begin
            n_fail++;
            $display("FAIL bubble_result: got valid=%b data=%0d expected 1 19", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_overflow();
        load_job(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        n_checks++;
        if ({mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {32'd1, 32'd2, 32'd3, 32'd4, 32'd5}) begin
            n_fail++;
            $display("FAIL overflow_second_job_ops: got %h", {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4});
        end
        tick();
        mx_finish   = 1'b1;
        mx_out      = 32'hFFFF_FFFF;
        mx_overflow = 1'b1;
        tick();
        mx_finish   = 1'b0;
        mx_out      = 32'h0;
        mx_overflow = 1'b0;
        n_checks++;
        if ({res_valid, res_overflow, res_timeout} !== 3'b110 || res_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL overflow_result: got flags=%b data=%h expected flags=110 data=ffffffff",
                     {res_valid, res_overflow, res_timeout}, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hA1 + i;
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, mx_start, busy, res_valid, res_overflow} !== 5'b10000 ||
            {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, res_data} !== 192'h0) begin
            n_fail++;
            $display("FAIL async_reset_load: got flags=%b words=%h expected flags=10000 words=0",
                     {in_ready, mx_start, busy, res_valid, res_overflow},
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, res_data});
        end
        #1 rst = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hB1 + i;
            tick();
            n_checks++;
            if (mx_start !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL async_reset_fresh_count word %0d: got start=%b ready=%b expected 0 1",
                         i, mx_start, in_ready);
            end
        end
        in_data = 32'hB5;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mx_start !== 1'b1 ||
            {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== {32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5}) begin
            n_fail++;
            $display("FAIL async_reset_reload: got start=%b ops=%h", mx_start,
                     {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4});
        end
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, mx_start, busy, res_valid} !== 4'b1000 ||
            {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4} !== 160'h0) begin
            n_fail++;
            $display("FAIL async_reset_wait: got flags=%b ops=%h expected flags=1000 ops=0",
                     {in_ready, mx_start, busy, res_valid}, {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4});
        end
        #1 rst = 1'b0;
        tick();
    endtask

`ifdef MAXNET_TIMEOUT_EN
    task automatic test_timeout();
        // finish in the expiry cycle wins
        load_job(32'h10, 32'h11, 32'h12, 32'h13, 32'h14);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_race_wait cycle %0d: got valid=%b expected 0", k, res_valid);
            end
        end
        mx_finish   = 1'b1;
        mx_out      = 32'h55;
        mx_overflow = 1'b1;
        tick();
        mx_finish   = 1'b0;
        mx_overflow = 1'b0;
        n_checks++;
        if ({res_valid, res_timeout, res_overflow} !== 3'b101 || res_data !== 32'h55) begin
            n_fail++;
            $display("FAIL timeout_race_result: got flags=%b data=%h expected flags=101 data=55",
                     {res_valid, res_timeout, res_overflow}, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        // engine never finishes
        load_job(32'h20, 32'h21, 32'h22, 32'h23, 32'h24);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait cycle %0d: got valid=%b expected 0", k, res_valid);
            end
        end
        tick();
        n_checks++;
        if ({res_valid, res_timeout, res_overflow} !== 3'b110 || res_data !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_expiry: got flags=%b data=%h expected flags=110 data=0",
                     {res_valid, res_timeout, res_overflow}, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask
`else
    task automatic test_wait_holds();
        load_job(32'h20, 32'h21, 32'h22, 32'h23, 32'h24);
        for (int k = 0; k < 40; k++) tick();
        n_checks++;
        if ({res_valid, busy, res_timeout} !== 3'b010) begin
            n_fail++;
            $display("FAIL wait_holds: got %b expected %b", {res_valid, busy, res_timeout}, 3'b010);
        end
        mx_finish = 1'b1;
        mx_out    = 32'h42;
        tick();
        mx_finish = 1'b0;
        n_checks++;
        if ({res_valid, res_timeout} !== 2'b10 || res_data !== 32'h42) begin
            n_fail++;
            $display("FAIL wait_holds_result: got flags=%b data=%h expected flags=10 data=42",
                     {res_valid, res_timeout}, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        mx_finish   = 1'b0;
        mx_overflow = 1'b0;
        mx_out      = 32'h0;
        res_ready   = 1'b0;
        test_reset();
        test_basic_load();
        test_result_capture();
        test_bubbled();
        test_overflow();
        test_async_reset();
`ifdef MAXNET_TIMEOUT_EN
        test_timeout();
`else
        test_wait_holds();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
